// File: rtl/cpu_pkg.sv
// cpu_pkg: shared load-type indices, bundle widths and TLB exception indices
package cpu_pkg;
  localparam int LD_W  = 0;
  localparam int LD_HU = 1;
  localparam int LD_H  = 2;
  localparam int LD_BU = 3;
  localparam int LD_B  = 4;
  localparam int EX_ZIP_W  = 87;
  localparam int TLB_ZIP_W = 10;
  localparam int TLB_EXC_W = 8;
  localparam int EARRAY_TLBR_FETCH = 0;
  localparam int EARRAY_PIF        = 1;
  localparam int EARRAY_PPI_FETCH  = 2;
  localparam int EARRAY_TLBR_MEM   = 3;
  localparam int EARRAY_PIL        = 4;
  localparam int EARRAY_PIS        = 5;
  localparam int EARRAY_PME        = 6;
  localparam int EARRAY_PPI_MEM    = 7;
endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: selects the addressed byte/half/word of a load response and extends it
module mem_load_ext
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [4:0]  ld_inst,
  output logic [31:0] data
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  // pick the addressed lane, then apply the extension the load type asks for
  always_comb begin
    byte_v = rdata[{offset, 3'b000} +: 8];
    half_v = rdata[{offset[1], 4'b0000} +: 16];
    data   = ld_inst[LD_B]  ? {{24{byte_v[7]}}, byte_v} :
             ld_inst[LD_BU] ? {24'b0, byte_v} :
             ld_inst[LD_H]  ? {{16{half_v[15]}}, half_v} :
             ld_inst[LD_HU] ? {16'b0, half_v} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for the data SRAM response, extends load data, drops orphaned responses (optional MS_PERF_CNT_EN adds ms_stall_cnt)
module mem_stage
  import cpu_pkg::*;
#(
  parameter int CANCEL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  output logic                 ms_allowin,
  input  logic [31:0]          es_pc,
  input  logic                 es_rf_we,
  input  logic [4:0]           es_rf_waddr,
  input  logic [31:0]          es_result,
  input  logic                 es_res_from_mem,
  input  logic [4:0]           es_ld_inst,
  input  logic                 es_mem_req,
  input  logic                 es_ex,
  input  logic [EX_ZIP_W-1:0]  es_ex_zip,
  input  logic [TLB_ZIP_W-1:0] es_tlb_zip,
  input  logic [TLB_EXC_W-1:0] es_tlb_exc,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allowin,
  input  logic                 wb_ex,
  output logic                 ms_to_ws_valid,
  output logic [31:0]          ms_pc,
  output logic                 ms_rf_we,
  output logic [4:0]           ms_rf_waddr,
  output logic [31:0]          ms_rf_wdata,
  output logic [EX_ZIP_W-1:0]  ms_ex_zip,
  output logic [TLB_ZIP_W-1:0] ms_tlb_zip,
  output logic [TLB_EXC_W-1:0] ms_tlb_exc,
  output logic                 ms_ex,
  output logic                 ms_fwd_we,
  output logic [4:0]           ms_fwd_waddr,
  output logic [31:0]          ms_fwd_wdata,
  output logic                 ms_ld_pending
`ifdef MS_PERF_CNT_EN
  ,
  output logic [31:0]          ms_stall_cnt
`endif
);
  logic                ms_valid;
  logic                ms_rf_we_r;
  logic [31:0]         ms_result;
  logic                ms_res_from_mem;
  logic [4:0]          ms_ld_inst;
  logic                ms_mem_wait;
  logic [31:0]         rbuf;
  logic                rbuf_valid;
  logic [CANCEL_W-1:0] cancel_cnt;
  logic                ms_ready_go;
  logic                capture;
  logic                accept;
  logic                no_cancel;
  logic [31:0]         ld_src;
  logic [31:0]         ld_data;

  assign no_cancel      = cancel_cnt == '0;
  assign ms_ready_go    = ~ms_mem_wait | rbuf_valid | (data_sram_data_ok & no_cancel);
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign capture        = es_to_ms_valid & ms_allowin;
  assign accept         = data_sram_data_ok & no_cancel & ms_valid & ms_mem_wait & ~rbuf_valid & ~wb_ex;
  assign ld_src         = rbuf_valid ? rbuf : data_sram_rdata;
  assign ms_ex          = ms_valid & (|ms_ex_zip[7:0] | |ms_tlb_exc);
  assign ms_rf_we       = ms_valid & ms_rf_we_r & ~ms_ex;
  assign ms_rf_wdata    = ms_res_from_mem ? ld_data : ms_result;
  assign ms_ld_pending  = ms_valid & ms_res_from_mem & ~ms_ready_go;
  assign ms_fwd_we      = ms_valid & ms_rf_we;
  assign ms_fwd_waddr   = ms_rf_waddr;
  assign ms_fwd_wdata   = ms_rf_wdata;

  mem_load_ext u_load_ext (
    .rdata   (ld_src),
    .offset  (ms_result[1:0]),
    .ld_inst (ms_ld_inst),
    .data    (ld_data)
  );

  // stage occupancy; a WB flush empties the stage regardless of handshakes
  always_ff @(posedge clk) begin
    if (reset) ms_valid <= 1'b0;
    else       ms_valid <= wb_ex ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
  end

  // payload capture from EX, and holding the response while WB stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_pc           <= '0;
      ms_rf_we_r      <= 1'b0;
      ms_rf_waddr     <= '0;
      ms_result       <= '0;
      ms_res_from_mem <= 1'b0;
      ms_ld_inst      <= '0;
      ms_mem_wait     <= 1'b0;
      ms_ex_zip       <= '0;
      ms_tlb_zip      <= '0;
      ms_tlb_exc      <= '0;
      rbuf            <= '0;
      rbuf_valid      <= 1'b0;
    end else if (capture) begin
      ms_pc           <= es_pc;
      ms_rf_we_r      <= es_rf_we;
      ms_rf_waddr     <= es_rf_waddr;
      ms_result       <= es_result;
      ms_res_from_mem <= es_res_from_mem;
      ms_ld_inst      <= es_ld_inst;
      ms_mem_wait     <= es_mem_req & ~es_ex;
      ms_ex_zip       <= es_ex_zip;
      ms_tlb_zip      <= es_tlb_zip;
      ms_tlb_exc      <= es_tlb_exc;
      rbuf_valid      <= 1'b0;
    end else if (accept) begin
      rbuf            <= data_sram_rdata;
      rbuf_valid      <= 1'b1;
    end
  end

  // count responses still owed to flushed requests so they are swallowed on arrival
  always_ff @(posedge clk) begin
    if (reset)
      cancel_cnt <= '0;
    else if (data_sram_data_ok & ~no_cancel)
      cancel_cnt <= cancel_cnt - 1'b1;
    else if (wb_ex & ms_valid & ms_mem_wait & ~rbuf_valid & ~data_sram_data_ok & (cancel_cnt != '1))
      cancel_cnt <= cancel_cnt + 1'b1;
  end

`ifdef MS_PERF_CNT_EN
  // cycles spent waiting on the data SRAM
  always_ff @(posedge clk) begin
    if (reset)                                  ms_stall_cnt <= '0;
    else if (ms_valid & ms_mem_wait & ~ms_ready_go) ms_stall_cnt <= ms_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
  import cpu_pkg::*;
  logic                 clk = 1'b0;
  logic                 reset;
  logic                 es_to_ms_valid;
  logic                 ms_allowin;
  logic [31:0]          es_pc;
  logic                 es_rf_we;
  logic [4:0]           es_rf_waddr;
  logic [31:0]          es_result;
  logic                 es_res_from_mem;
  logic [4:0]           es_ld_inst;
  logic                 es_mem_req;
  logic                 es_ex;
  logic [EX_ZIP_W-1:0]  es_ex_zip;
  logic [TLB_ZIP_W-1:0] es_tlb_zip;
  logic [TLB_EXC_W-1:0] es_tlb_exc;
  logic                 data_sram_data_ok;
  logic [31:0]          data_sram_rdata;
  logic                 ws_allowin;
  logic                 wb_ex;
  logic                 ms_to_ws_valid;
  logic [31:0]          ms_pc;
  logic                 ms_rf_we;
  logic [4:0]           ms_rf_waddr;
  logic [31:0]          ms_rf_wdata;
  logic [EX_ZIP_W-1:0]  ms_ex_zip;
  logic [TLB_ZIP_W-1:0] ms_tlb_zip;
  logic [TLB_EXC_W-1:0] ms_tlb_exc;
  logic                 ms_ex;
  logic                 ms_fwd_we;
  logic [4:0]           ms_fwd_waddr;
  logic [31:0]          ms_fwd_wdata;
  logic                 ms_ld_pending;
  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_result(es_result),
    .es_res_from_mem(es_res_from_mem), .es_ld_inst(es_ld_inst), .es_mem_req(es_mem_req),
    .es_ex(es_ex), .es_ex_zip(es_ex_zip), .es_tlb_zip(es_tlb_zip), .es_tlb_exc(es_tlb_exc),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .wb_ex(wb_ex), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_ex_zip(ms_ex_zip), .ms_tlb_zip(ms_tlb_zip), .ms_tlb_exc(ms_tlb_exc), .ms_ex(ms_ex),
    .ms_fwd_we(ms_fwd_we), .ms_fwd_waddr(ms_fwd_waddr), .ms_fwd_wdata(ms_fwd_wdata),
    .ms_ld_pending(ms_ld_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] res,
                       input logic from_mem, input logic [4:0] ld, input logic req);
    es_to_ms_valid  = 1'b1;
    es_pc           = pc;
    es_rf_we        = 1'b1;
    es_rf_waddr     = wa;
    es_result       = res;
    es_res_from_mem = from_mem;
    es_ld_inst      = ld;
    es_mem_req      = req;
    tick();
    es_to_ms_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; es_to_ms_valid = 0; es_pc = 0; es_rf_we = 0; es_rf_waddr = 0; es_result = 0;
    es_res_from_mem = 0; es_ld_inst = 0; es_mem_req = 0; es_ex = 0; es_ex_zip = '0;
    es_tlb_zip = '0; es_tlb_exc = '0; data_sram_data_ok = 0; data_sram_rdata = 0;
    ws_allowin = 1; wb_ex = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_wdata", ms_rf_wdata, 32'd0);
    chk("rst_pc", ms_pc, 32'd0);

    issue(32'h1c00_0000, 5'd3, 32'h1000_0003, 1'b1, 5'b10000, 1'b1);
    #1;
    chk("ldb_pend1", 32'(ms_ld_pending), 32'd1);
    chk("ldb_nvalid", 32'(ms_to_ws_valid), 32'd0);
    tick(); #1;
    chk("ldb_pend2", 32'(ms_ld_pending), 32'd1);
    tick();
    data_sram_data_ok = 1; data_sram_rdata = 32'h80FF_1234;
    #1;
    chk("ldb_pend0", 32'(ms_ld_pending), 32'd0);
    chk("ldb_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("ldb_wdata", ms_rf_wdata, 32'hFFFF_FF80);
    chk("ldb_fwd", ms_fwd_wdata, 32'hFFFF_FF80);
    chk("ldb_pc", ms_pc, 32'h1c00_0000);
    tick();
    data_sram_data_ok = 0;
    #1;
    chk("ldb_gone", 32'(ms_to_ws_valid), 32'd0);

    issue(32'h1c00_0004, 5'd4, 32'h1000_0002, 1'b1, 5'b00010, 1'b1);
    ws_allowin = 0; data_sram_data_ok = 1; data_sram_rdata = 32'hBEEF_0001;
    #1;
    chk("ldhu_live", ms_rf_wdata, 32'h0000_BEEF);
    chk("ldhu_stall_allowin", 32'(ms_allowin), 32'd0);
    tick();
    data_sram_data_ok = 0; data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    chk("ldhu_hold1", ms_rf_wdata, 32'h0000_BEEF);
    chk("ldhu_valid1", 32'(ms_to_ws_valid), 32'd1);
    tick(); #1;
    chk("ldhu_hold2", ms_rf_wdata, 32'h0000_BEEF);
    tick();
    ws_allowin = 1;
    #1;
    chk("ldhu_rel", ms_rf_wdata, 32'h0000_BEEF);
    chk("ldhu_rel_allowin", 32'(ms_allowin), 32'd1);
    tick(); #1;
    chk("ldhu_once", 32'(ms_to_ws_valid), 32'd0);

    issue(32'h1c00_0008, 5'd6, 32'h1000_0000, 1'b1, 5'b00001, 1'b1);
    wb_ex = 1;
    tick();
    wb_ex = 0;
    #1;
    chk("cnl_valid", 32'(dut.ms_valid), 32'd0);
    chk("cnl_cnt1", 32'(dut.cancel_cnt), 32'd1);
    chk("cnl_allowin", 32'(ms_allowin), 32'd1);
    issue(32'h1c00_000c, 5'd7, 32'h2000_0000, 1'b1, 5'b00001, 1'b1);
    data_sram_data_ok = 1; data_sram_rdata = 32'h0000_DEAD;
    #1;
    chk("cnl_stale_nvalid", 32'(ms_to_ws_valid), 32'd0);
    chk("cnl_stale_pend", 32'(ms_ld_pending), 32'd1);
    tick();
    data_sram_data_ok = 0;
    #1;
    chk("cnl_cnt0", 32'(dut.cancel_cnt), 32'd0);
    chk("cnl_still_pend", 32'(ms_ld_pending), 32'd1);
    tick();
    data_sram_data_ok = 1; data_sram_rdata = 32'h1234_5678;
    #1;
    chk("cnl_valid2", 32'(ms_to_ws_valid), 32'd1);
    chk("cnl_wdata", ms_rf_wdata, 32'h1234_5678);
    chk("cnl_waddr", 32'(ms_rf_waddr), 32'd7);
    tick();
    data_sram_data_ok = 0;

    es_ex = 1; es_ex_zip = '0; es_ex_zip[6] = 1'b1;
    issue(32'h1c00_0010, 5'd8, 32'h1000_0001, 1'b0, 5'b00000, 1'b1);
    es_ex = 0; es_ex_zip = '0;
    #1;
    chk("ale_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("ale_ex", 32'(ms_ex), 32'd1);
    chk("ale_rfwe", 32'(ms_rf_we), 32'd0);
    chk("ale_fwdwe", 32'(ms_fwd_we), 32'd0);
    chk("ale_zip", ms_ex_zip[31:0], 32'h0000_0040);

    es_tlb_zip = 10'h155;
    issue(32'h1c00_0014, 5'd5, 32'h0000_0042, 1'b0, 5'b00000, 1'b0);
    es_tlb_zip = '0;
    #1;
    chk("add_fwdwe", 32'(ms_fwd_we), 32'd1);
    chk("add_fwdwa", 32'(ms_fwd_waddr), 32'd5);
    chk("add_fwdwd", ms_fwd_wdata, 32'h0000_0042);
    chk("add_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("add_tlbzip", 32'(ms_tlb_zip), 32'h155);

    es_tlb_exc = 8'h04;
    issue(32'h1c00_0018, 5'd9, 32'h0000_0011, 1'b0, 5'b00000, 1'b0);
    es_tlb_exc = '0;
    #1;
    chk("tlbexc_ex", 32'(ms_ex), 32'd1);
    chk("tlbexc_rfwe", 32'(ms_rf_we), 32'd0);
    chk("tlbexc_pass", 32'(ms_tlb_exc), 32'h04);

    issue(32'h1c00_001c, 5'd10, 32'h3000_0000, 1'b1, 5'b00001, 1'b1);
    wb_ex = 1;
    tick();
    wb_ex = 0;
    issue(32'h1c00_0020, 5'd11, 32'h3000_0004, 1'b1, 5'b00001, 1'b1);
    #1;
    chk("rstw_pend", 32'(ms_ld_pending), 32'd1);
    chk("rstw_cnt", 32'(dut.cancel_cnt), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rstw_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("rstw_allowin", 32'(ms_allowin), 32'd1);
    chk("rstw_pc", ms_pc, 32'd0);
    chk("rstw_wdata", ms_rf_wdata, 32'd0);
    chk("rstw_pend0", 32'(ms_ld_pending), 32'd0);
    chk("rstw_fwdwe", 32'(ms_fwd_we), 32'd0);
    chk("rstw_waddr", 32'(ms_rf_waddr), 32'd0);
    chk("rstw_cnt0", 32'(dut.cancel_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the EX stage and upstream of WB.
- Tracks the data-SRAM transaction that EX issued: waits for data_ok, then buffers, aligns and sign/zero-extends read data.
- Merges load data with the EX result and passes exception/TLB bundles to WB.
- Discards responses to requests orphaned by a WB flush, and drives forwarding/load-use info to ID.

Parameters:
- CANCEL_W, 2, width of the orphaned-response counter.

Ports:
- clk in 1: clock
- reset in 1: reset
- es_to_ms_valid in 1: EX has an instruction for MEM
- ms_allowin out 1: MEM can accept
- es_pc in 32: EX pc
- es_rf_we in 1: register write enable
- es_rf_waddr in 5: destination register
- es_result in 32: ALU/counter result; bits [1:0] are the load byte offset
- es_res_from_mem in 1: instruction is a load
- es_ld_inst in 5: {ld_b, ld_bu, ld_h, ld_hu, ld_w}
- es_mem_req in 1: instruction is a load or store
- es_ex in 1: EX-detected exception (no SRAM request was issued)
- es_ex_zip in 87: exception bundle, passed through
- es_tlb_zip in 10: TLB-op bundle, passed through
- es_tlb_exc in 8: TLB exception vector, passed through
- data_sram_data_ok in 1: response valid
- data_sram_rdata in 32: response data
- ws_allowin in 1: WB can accept
- wb_ex in 1: flush, asserted by WB on exception or ertn
- ms_to_ws_valid out 1: valid to WB
- ms_pc out 32: pc to WB
- ms_rf_we out 1: register write enable to WB
- ms_rf_waddr out 5: destination register to WB
- ms_rf_wdata out 32: final write data
- ms_ex_zip out 87: exception bundle to WB
- ms_tlb_zip out 10: TLB bundle to WB
- ms_tlb_exc out 8: TLB exception vector to WB
- ms_ex out 1: MEM holds an excepting instruction; EX uses it to block requests
- ms_fwd_we out 1: forward valid (ms_valid & ms_rf_we)
- ms_fwd_waddr out 5: forwarded register
- ms_fwd_wdata out 32: forwarded data, equal to ms_rf_wdata
- ms_ld_pending out 1: load in MEM with data not yet available; ID must stall

Behaviour:
- Reset: synchronous, active-high. It clears ms_valid, all payload registers, cancel_cnt, rbuf_valid and the performance counter. Consequently every output resets to 0, except ms_allowin, which resets to 1.
- Capture on es_to_ms_valid & ms_allowin:
  - Register all payload fields.
  - ms_mem_wait <= es_mem_req & ~es_ex (a request is outstanding).
  - rbuf_valid <= 0.
- ms_valid:
  - Cleared on wb_ex (highest priority).
  - Otherwise loaded with es_to_ms_valid when ms_allowin.
- ms_ready_go = ~ms_mem_wait | rbuf_valid | (data_ok & cancel_cnt==0).
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go.
- Response accepted when data_ok & cancel_cnt==0 & ms_valid & ms_mem_wait & ~rbuf_valid:
  - Latch rdata into rbuf and set rbuf_valid.
  - rbuf_valid stays set until the next capture; rdata is held while WB stalls.
- Load data source: rbuf if rbuf_valid, else live rdata.
- Byte/half selection uses the offset ms_result[1:0]; byte = data[8*off +: 8], half = data[16*off[1] +: 16].
  - ld_b / ld_h sign-extend; ld_bu / ld_hu zero-extend; ld_w takes the word.
- ms_rf_wdata = ms_res_from_mem ? extended load data : ms_result.
- ms_ld_pending = ms_valid & ms_res_from_mem & ~ms_ready_go.
- ms_ex = ms_valid & (|ms_ex_zip[7:0] | |ms_tlb_exc).
- ms_rf_we is gated by ms_valid & ~ms_ex.
- Cancel:
  - When wb_ex arrives while ms_valid & ms_mem_wait & ~rbuf_valid and no data_ok arrives that cycle, cancel_cnt increments, saturating at 2^CANCEL_W-1.
  - While cancel_cnt>0, each data_ok decrements it and is never accepted.
  - If wb_ex and an acceptable data_ok coincide, the data is dropped and no increment occurs.
  - EX never issues a request in a wb_ex cycle, so only MEM's own outstanding request is counted.
- Back-to-back operation: a new capture may happen in the same cycle a stale data_ok is decremented; that stale response is not applied to the new instruction.

Optional Feature:
- MS_PERF_CNT_EN
  - Defined: adds output ms_stall_cnt (32 bits). It increments each cycle ms_valid & ms_mem_wait & ~ms_ready_go, wraps at 2^32, and is cleared by reset.
  - Undefined: no port, no logic.

Decomposition:
- Shared package cpu_pkg holds:
  - LD one-hot bit indices.
  - EX_ZIP_W=87, TLB_ZIP_W=10, TLB_EXC_W=8.
  - The EARRAY_* TLB exception indices.
- Sub-module mem_load_ext (combinational): takes rdata, offset and ld_inst, and produces the extended 32-bit value.

Test Plan:
- ld_b with result 0x1000_0003, rdata 0x80FF_1234, data_ok 2 cycles after capture -> ms_ld_pending=1 for 2 cycles, then ms_rf_wdata=0xFFFF_FF80 and ms_to_ws_valid=1.
- ld_hu with offset 2, rdata 0xBEEF_0001, ws_allowin=0 for 3 cycles after data_ok -> rbuf holds; on release ms_rf_wdata=0x0000_BEEF, transferred exactly once.
- Load waiting with wb_ex pulsed before data_ok -> ms_valid=0 and cancel_cnt=1. A new ld_w is captured; the first data_ok (0xDEAD) is dropped and cancel_cnt returns to 0; the second data_ok (0x1234_5678) gives ms_rf_wdata=0x1234_5678.
- Store with es_ex=1 (ALE) -> no wait; ms_to_ws_valid the next cycle, ms_ex=1, ms_rf_we=0.
- Non-memory add with result 0x42 and rf_waddr=5 -> ms_fwd_we=1, ms_fwd_waddr=5, ms_fwd_wdata=0x42 in the cycle after capture.
- Reset asserted mid-wait -> the next cycle all outputs are 0, ms_allowin=1 and cancel_cnt=0.
